paddle_input: RTL and testbench
===============================

PADDLE_INPUT -- requirements
Module: paddle_input

Interface
REQ-001 Parameter DB_CYCLES, default 50000, consecutive cycles a synchronized button level must differ from its debounced level before the debounced level changes (range 1..65535).
REQ-002 Parameter TICK_DIV, default 65536, clock cycles per movement tick (range 2..65536).
REQ-003 Parameter ACCEL_TICKS, default 32, consecutive held ticks before the step size rises from 1 to 2 (range 1..255).
REQ-004 Parameter Y_CENTRE, default 240, paddle centre position after reset or re-centre.
REQ-005 clk  in  1  single system clock; one clock, reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 p1_up, p1_dn, p2_up, p2_dn  in  1 each  raw asynchronous push buttons, active-high; up decreases y.
REQ-008 bat_size  in  1  0 = large paddle (half-height 29), 1 = small paddle (half-height 19).
REQ-009 centre  in  1  synchronous single-cycle request to return both paddles to Y_CENTRE.
REQ-010 p1_y, p2_y  out  11 each  registered paddle centre positions, consumed directly as the game controller's p1_in / p2_in.
REQ-011 tick  out  1  registered one-cycle movement strobe, for debug and bench alignment.

Function
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per button debouncer: a counter SHALL increment while the synchronized level differs from the debounced level and clear when they match; when the counter reaches DB_CYCLES-1 and the levels still differ, the debounced level SHALL toggle and the counter SHALL clear.
REQ-014 Latency from a clean raw edge to a debounced edge SHALL be exactly 2 + DB_CYCLES cycles; glitches shorter than DB_CYCLES cycles SHALL NOT change the debounced level.
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be 1 in the cycle after the counter reaches TICK_DIV-1, so exactly one tick occurs every TICK_DIV cycles.
REQ-016 Limits SHALL be computed from bat_size: large -> y_min 60, y_max 420; small -> y_min 50, y_max 430 (field 30..450, minus half-height, minus 1).
REQ-017 Per player direction: up-only = UP, down-only = DOWN, both or neither = IDLE, using debounced levels.
REQ-018 Per player hold counter (8 bit): on a tick with direction UP/DOWN equal to the previous tick's direction, it SHALL increment, saturating at ACCEL_TICKS; on a tick with IDLE or a changed direction, it SHALL load 0 (IDLE) or 1 (new direction).
REQ-019 Step SHALL be 2 when the hold counter equals ACCEL_TICKS, else 1.
REQ-020 On a tick: UP -> y = max(y_min, y - step); DOWN -> y = min(y_max, y + step); IDLE -> y held; updates SHALL appear on p1_y/p2_y the cycle after tick.
REQ-021 Between ticks, positions SHALL be unchanged except per REQ-022/REQ-023.
REQ-022 On any cycle where y < y_min or y > y_max (e.g. after bat_size changes 1->0), y SHALL be clamped to the violated limit on the next cycle, regardless of tick.
REQ-023 centre = 1 SHALL load both positions to Y_CENTRE and clear both hold counters the next cycle; the tick counter and debouncers are not affected.
REQ-024 Priority per cycle: rst > centre > clamp > tick movement.
REQ-025 Players SHALL be fully independent; simultaneous activity on both players SHALL be processed in the same cycle.
REQ-026 Arithmetic SHALL be 11-bit unsigned; subtraction SHALL never wrap because limit checks precede the step.

Reset
REQ-027 On rst: p1_y = p2_y = Y_CENTRE, tick = 0, tick counter = 0, all synchronizer flops, debounced levels and debounce counters = 0, hold counters = 0, previous directions = IDLE.
REQ-028 rst asserted mid-debounce or mid-hold SHALL discard all progress; the first tick after release SHALL occur TICK_DIV cycles after the cycle in which rst is low.

Verification (DB_CYCLES=4, TICK_DIV=8, ACCEL_TICKS=4, Y_CENTRE=240)
REQ-029 Reset then idle 64 cycles -> p1_y = p2_y = 240, tick pulses every 8 cycles, one cycle wide.
REQ-030 p1_dn raw pulse 3 cycles wide -> debounced level never rises, p1_y stays 240; p1_dn held -> debounced high 6 cycles after raw edge, p1_y 241, 242, 243, 244 on successive ticks, then 246, 248 (accelerated).
REQ-031 p2_up held long with bat_size=0 -> p2_y decreases to 60 and holds; both p2 buttons held -> p2_y unchanged, hold counter cleared, next single-direction tick steps by 1.
REQ-032 bat_size=1, p1 driven to 430; switch bat_size to 0 -> p1_y = 420 the next cycle without waiting for a tick.
REQ-033 centre pulsed on the same cycle as a tick with p1_dn held -> p1_y = 240 (centre wins), next tick steps by 1 to 241.
REQ-034 rst asserted for 1 cycle while p1 accelerated at 300 -> p1_y = 240, step resumes at 1 only after full re-debounce (6 cycles) of the still-held button.

Source files
------------

// File: rtl/paddle_input.sv
// Paddle input front end: synchronizes and debounces four raw push buttons,
// generates a periodic movement tick, and moves two paddle centres with
// hold-to-accelerate, bat-size dependent limits and a re-centre request.
module paddle_input #(
  parameter int DB_CYCLES   = 50000,
  parameter int TICK_DIV    = 65536,
  parameter int ACCEL_TICKS = 32,
  parameter int Y_CENTRE    = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic        bat_size,
  input  logic        centre,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic        tick
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  ACCEL_MAX = 8'(ACCEL_TICKS);
  localparam logic [10:0] Y_INIT    = 11'(Y_CENTRE);

  // Button vector order: {p2_dn, p2_up, p1_dn, p1_up}; player p owns bits 2p (up) and 2p+1 (down).
  logic [3:0]  btn;
  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  deb;
  logic [15:0] db_cnt [4];

  logic [15:0] tick_cnt;

  logic [10:0] y_q    [2];
  logic [7:0]  hold_q [2];
  dir_t        prev_q [2];

  logic [10:0] y_nxt    [2];
  logic [7:0]  hold_nxt [2];
  dir_t        prev_nxt [2];
  dir_t        dir      [2];
  logic [10:0] step     [2];

  logic [10:0] y_min;
  logic [10:0] y_max;

  assign btn  = {p2_dn, p2_up, p1_dn, p1_up};
  assign p1_y = y_q[0];
  assign p2_y = y_q[1];

  // Limits follow the paddle half-height so the paddle stays inside the field.
  assign y_min = bat_size ? 11'd50  : 11'd60;
  assign y_max = bat_size ? 11'd430 : 11'd420;

  // Two-flop synchronizers, then a per-button counter that toggles the
  // debounced level after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= ~deb[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Free-running tick divider; tick is the registered wrap strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? 16'd0 : tick_cnt + 16'd1;
      tick     <= (tick_cnt == TICK_LAST);
    end
  end

  // Per-player next position and hold state; priority centre > clamp > tick move.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      y_nxt[p]    = y_q[p];
      hold_nxt[p] = hold_q[p];
      prev_nxt[p] = prev_q[p];
      dir[p]      = DIR_IDLE;
      step[p]     = 11'd1;

      if (deb[2*p] && !deb[2*p+1])      dir[p] = DIR_UP;
      else if (!deb[2*p] && deb[2*p+1]) dir[p] = DIR_DN;

      // The step accelerates only while the same direction keeps being held.
      if (dir[p] == prev_q[p] && hold_q[p] == ACCEL_MAX) step[p] = 11'd2;

      if (centre) begin
        y_nxt[p]    = Y_INIT;
        hold_nxt[p] = '0;
        prev_nxt[p] = DIR_IDLE;
      end else begin
        if (y_q[p] < y_min) begin
          y_nxt[p] = y_min;
        end else if (y_q[p] > y_max) begin
          y_nxt[p] = y_max;
        end else if (tick) begin
          // y is within limits here, so comparing against limit+-step avoids any wrap.
          if (dir[p] == DIR_UP)
            y_nxt[p] = (y_q[p] >= y_min + step[p]) ? y_q[p] - step[p] : y_min;
          else if (dir[p] == DIR_DN)
            y_nxt[p] = (y_q[p] + step[p] <= y_max) ? y_q[p] + step[p] : y_max;
        end

        if (tick) begin
          if (dir[p] == DIR_IDLE)
            hold_nxt[p] = '0;
          else if (dir[p] == prev_q[p])
            hold_nxt[p] = (hold_q[p] >= ACCEL_MAX) ? hold_q[p] : hold_q[p] + 8'd1;
          else
            hold_nxt[p] = 8'd1;
          prev_nxt[p] = dir[p];
        end
      end
    end
  end

  // Paddle state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        y_q[p]    <= Y_INIT;
        hold_q[p] <= '0;
        prev_q[p] <= DIR_IDLE;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        y_q[p]    <= y_nxt[p];
        hold_q[p] <= hold_nxt[p];
        prev_q[p] <= prev_nxt[p];
      end
    end
  end

endmodule

// File: tb/tb_paddle_input.sv
// Bench for paddle_input: directed scenarios plus randomized button activity,
// all checked every cycle against a behavioural model of the paddle rules.
module tb_paddle_input;

  localparam int DB = 4;
  localparam int TD = 8;
  localparam int AC = 4;
  localparam int YC = 240;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic        bat_size = 1'b0;
  logic        centre = 1'b0;
  logic [10:0] p1_y, p2_y;
  logic        tick;

  int n_checks = 0;
  int n_fail   = 0;

  paddle_input #(
    .DB_CYCLES(DB), .TICK_DIV(TD), .ACCEL_TICKS(AC), .Y_CENTRE(YC)
  ) dut (
    .clk(clk), .rst(rst),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .bat_size(bat_size), .centre(centre),
    .p1_y(p1_y), .p2_y(p2_y), .tick(tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Directions as -1 (up), 0 (idle), +1 (down); run = consecutive ticks held in one direction.
  int m_y [2];
  int m_run [2];
  int m_prev [2];
  bit m_deb [4];
  bit m_hist [4][2];   // raw samples from the last two edges
  bit m_win [4][DB];   // last DB synchronized samples seen by the debouncer
  int m_n;
  bit m_tick;
  bit m_valid = 1'b0;
  bit raw [4];
  int lo, hi, d, st;
  bit all_diff;

  always @(posedge clk) begin
    raw[0] = p1_up; raw[1] = p1_dn; raw[2] = p2_up; raw[3] = p2_dn;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_y[p] = YC; m_run[p] = 0; m_prev[p] = 0;
      end
      for (int b = 0; b < 4; b++) begin
        m_deb[b] = 0; m_hist[b][0] = 0; m_hist[b][1] = 0;
        for (int k = 0; k < DB; k++) m_win[b][k] = 0;
      end
      m_n = 0; m_tick = 0;
    end else begin
      lo = bat_size ? 50 : 60;
      hi = bat_size ? 430 : 420;
      for (int p = 0; p < 2; p++) begin
        d = 0;
        if (m_deb[2*p] && !m_deb[2*p+1]) d = -1;
        if (!m_deb[2*p] && m_deb[2*p+1]) d = 1;
        if (centre) begin
          m_y[p] = YC; m_run[p] = 0; m_prev[p] = 0;
        end else begin
          if (m_y[p] < lo) m_y[p] = lo;
          else if (m_y[p] > hi) m_y[p] = hi;
          else if (m_tick && d != 0) begin
            st = (d == m_prev[p] && m_run[p] >= AC) ? 2 : 1;
            m_y[p] = m_y[p] + d * st;
            if (m_y[p] < lo) m_y[p] = lo;
            if (m_y[p] > hi) m_y[p] = hi;
          end
          if (m_tick) begin
            if (d == 0) m_run[p] = 0;
            else if (d == m_prev[p]) m_run[p] = m_run[p] + 1;
            else m_run[p] = 1;
            m_prev[p] = d;
          end
        end
      end
      for (int b = 0; b < 4; b++) begin
        for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
        m_win[b][0] = m_hist[b][1];
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (m_win[b][k] == m_deb[b]) all_diff = 0;
        if (all_diff) m_deb[b] = ~m_deb[b];
        m_hist[b][1] = m_hist[b][0];
        m_hist[b][0] = raw[b];
      end
      m_n++;
      m_tick = (m_n % TD == 0);
    end
    m_valid = 1'b1;
  end

  // scoreboard: every cycle, outputs versus the model
  always @(negedge clk) begin
    if (m_valid) begin
      check_eq("model_p1_y", 32'(p1_y), 32'(m_y[0]));
      check_eq("model_p2_y", 32'(p2_y), 32'(m_y[1]));
      check_eq("model_tick", 32'(tick), 32'(m_tick));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    wait_cycles(n);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int ticks_seen;
  int got;
  int last_y;
  int exp_seq [6] = '{241, 242, 243, 244, 246, 248};
  logic [10:0] seq_q [$];
  logic [3:0] btns, gmask;
  int dur;
  bit found;

  initial begin
    do_reset(3);
    @(negedge clk);
    check_eq("reset_p1_y", 32'(p1_y), 32'(YC));
    check_eq("reset_p2_y", 32'(p2_y), 32'(YC));

    // idle: exactly one tick per TD cycles
    ticks_seen = 0;
    repeat (64) begin
      @(negedge clk);
      if (tick) ticks_seen++;
    end
    check_eq("idle_tick_count", 32'(ticks_seen), 32'(64 / TD));

    // 3-cycle glitch must not move the paddle
    p1_dn = 1'b1; wait_cycles(3); p1_dn = 1'b0;
    wait_cycles(40);
    check_eq("glitch_p1_y", 32'(p1_y), 32'(YC));

    // held down: 1,1,1,1 then accelerated 2,2
    p1_dn = 1'b1;
    last_y = p1_y;
    seq_q.delete();
    for (int i = 0; i < 300 && seq_q.size() < 6; i++) begin
      @(negedge clk);
      if (p1_y != 11'(last_y)) begin
        seq_q.push_back(p1_y);
        last_y = p1_y;
      end
    end
    check_eq("accel_change_count", 32'(seq_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < seq_q.size(); i++)
      check_eq("accel_seq", 32'(seq_q[i]), 32'(exp_seq[i]));

    // centre coinciding with a tick wins, then steps resume at 1
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tick) found = 1;
    end
    check_eq("tick_found", 32'(found), 32'd1);
    centre = 1'b1;
    @(negedge clk);
    centre = 1'b0;
    check_eq("centre_p1_y", 32'(p1_y), 32'(YC));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (p1_y != 11'(YC)) found = 1;
    end
    check_eq("after_centre_p1_y", 32'(p1_y), 32'(YC + 1));

    // reset while accelerated discards progress
    wait_cycles(80);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_p1_y", 32'(p1_y), 32'(YC));
    check_eq("rst_mid_tick", 32'(tick), 32'd0);
    wait_cycles(60);
    p1_dn = 1'b0;
    wait_cycles(20);

    // p2 up to the large-paddle top limit, then both buttons held
    bat_size = 1'b0;
    p2_up = 1'b1;
    found = 0;
    for (int i = 0; i < 2500 && !found; i++) begin
      @(negedge clk);
      if (p2_y == 11'd60) found = 1;
    end
    check_eq("p2_reach_min", 32'(found), 32'd1);
    wait_cycles(50);
    check_eq("p2_hold_min", 32'(p2_y), 32'd60);
    p2_dn = 1'b1;
    wait_cycles(60);
    check_eq("p2_both_held", 32'(p2_y), 32'd60);
    p2_up = 1'b0;
    p2_dn = 1'b0;
    wait_cycles(20);

    // p1 to small-paddle bottom limit, then switching to large clamps at once
    bat_size = 1'b1;
    p1_dn = 1'b1;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (p1_y == 11'd430) found = 1;
    end
    check_eq("p1_reach_max", 32'(found), 32'd1);
    p1_dn = 1'b0;
    wait_cycles(3);
    bat_size = 1'b0;
    @(negedge clk);
    check_eq("bat_switch_clamp", 32'(p1_y), 32'd420);
    wait_cycles(20);

    // randomized segments: held button sets with glitches, centre, size and reset events
    for (int seg = 0; seg < 60; seg++) begin
      dur  = ($urandom_range(0, 4) == 0) ? $urandom_range(400, 1200) : $urandom_range(5, 200);
      btns = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) bat_size = ~bat_size;
      repeat (dur) begin
        gmask = ($urandom_range(0, 39) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
        {p2_dn, p2_up, p1_dn, p1_up} = btns ^ gmask;
        centre = ($urandom_range(0, 149) == 0);
        rst    = ($urandom_range(0, 1499) == 0);
        @(negedge clk);
      end
      centre = 1'b0;
      rst    = 1'b0;
    end
    {p2_dn, p2_up, p1_dn, p1_up} = 4'd0;
    wait_cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
